// File: rtl/aclk_alarm_sequencer.sv
// Alarm sequencer: rings on a rising edge of the time/alarm match and runs
// ring and snooze periods in whole minutes using the minute strobe.
module aclk_alarm_sequencer #(
    parameter int RING_MINUTES   = 5,
    parameter int SNOOZE_MINUTES = 9,
    parameter int MAX_SNOOZES    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        one_minute,
    input  logic [15:0] current_time,
    input  logic [15:0] alarm_time,
    input  logic        alarm_enable,
    input  logic        snooze_button,
    input  logic        stop_button,
    output logic        sound_alarm,
    output logic        snoozing,
    output logic [3:0]  snooze_count,
    output logic [3:0]  minutes_left
);

    localparam logic [3:0] RING_M   = 4'(RING_MINUTES);
    localparam logic [3:0] SNOOZE_M = 4'(SNOOZE_MINUTES);
    localparam logic [3:0] MAX_SN   = 4'(MAX_SNOOZES);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    state_t      state, state_n;
    logic        match, match_q, trigger;
    logic [3:0]  left_n, cnt_n;

    assign match   = (current_time == alarm_time);
    assign trigger = alarm_enable & match & ~match_q;

    // match_q resets high so equal times at power-up are not a rising edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            match_q      <= 1'b1;
            minutes_left <= 4'd0;
            snooze_count <= 4'd0;
        end else begin
            state        <= state_n;
            match_q      <= match;
            minutes_left <= left_n;
            snooze_count <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        left_n  = minutes_left;
        cnt_n   = snooze_count;
        if (!alarm_enable) begin
            state_n = IDLE;
            left_n  = 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trigger) begin
                        state_n = RING;
                        left_n  = RING_M;
                        cnt_n   = 4'd0;
                    end
                end
                RING: begin
                    if (stop_button) begin
                        state_n = IDLE;
                        left_n  = 4'd0;
                    end else if (snooze_button && (snooze_count < MAX_SN)) begin
                        state_n = SNOOZE;
                        left_n  = SNOOZE_M;
                        cnt_n   = snooze_count + 4'd1;
                    end else if (one_minute) begin
                        if (minutes_left == 4'd1) begin
                            state_n = IDLE;
                            left_n  = 4'd0;
                        end else begin
                            left_n = minutes_left - 4'd1;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_button) begin
                        state_n = IDLE;
                        left_n  = 4'd0;
                    end else if (one_minute) begin
                        if (minutes_left == 4'd1) begin
                            state_n = RING;
                            left_n  = RING_M;
                        end else begin
                            left_n = minutes_left - 4'd1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    left_n  = 4'd0;
                end
            endcase
        end
    end

    assign sound_alarm = (state == RING);
    assign snoozing    = (state == SNOOZE);

endmodule

// File: tb/tb_aclk_alarm_sequencer.sv
// Self-checking bench: directed test-plan scenarios with literal expectations,
// then random stimulus compared every cycle against a behavioural model.
module tb_aclk_alarm_sequencer;

    localparam int RING   = 5;
    localparam int SNZ    = 9;
    localparam int MAXSNZ = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        one_minute = 1'b0;
    logic [15:0] current_time = 16'h1039;
    logic [15:0] alarm_time = 16'h1040;
    logic        alarm_enable = 1'b1;
    logic        snooze_button = 1'b0;
    logic        stop_button = 1'b0;
    logic        sound_alarm, snoozing;
    logic [3:0]  snooze_count, minutes_left;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    aclk_alarm_sequencer #(.RING_MINUTES(RING), .SNOOZE_MINUTES(SNZ), .MAX_SNOOZES(MAXSNZ)) dut (
        .clk(clk), .reset(reset), .one_minute(one_minute),
        .current_time(current_time), .alarm_time(alarm_time),
        .alarm_enable(alarm_enable), .snooze_button(snooze_button),
        .stop_button(stop_button), .sound_alarm(sound_alarm),
        .snoozing(snoozing), .snooze_count(snooze_count),
        .minutes_left(minutes_left)
    );

    // Model: mode 0 = quiet, 1 = ringing, 2 = snoozing; left counts whole minutes
    typedef struct {
        int mode;
        int left;
        int cnt;
        bit prev;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t next_m(mdl_t c, bit hit, bit en, bit stop, bit snz, bit minute);
        mdl_t n = c;
        if (!en) begin
            n.mode = 0; n.left = 0;
        end else if (c.mode == 0) begin
            if (hit && !c.prev) begin n.mode = 1; n.left = RING; n.cnt = 0; end
        end else if (stop) begin
            n.mode = 0; n.left = 0;
        end else if (c.mode == 1 && snz && c.cnt < MAXSNZ) begin
            n.mode = 2; n.left = SNZ; n.cnt = c.cnt + 1;
        end else if (minute) begin
            n.left = c.left - 1;
            if (n.left == 0) begin
                if (c.mode == 1) n.mode = 0;
                else begin n.mode = 1; n.left = RING; end
            end
        end
        n.prev = hit;
        return n;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '{mode: 0, left: 0, cnt: 0, prev: 1'b1};
        else m <= next_m(m, current_time == alarm_time, alarm_enable,
                         stop_button, snooze_button, one_minute);
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model sound_alarm", 16'(sound_alarm), 16'(m.mode == 1));
        chk("model snoozing", 16'(snoozing), 16'(m.mode == 2));
        chk("model snooze_count", 16'(snooze_count), 16'(m.cnt));
        chk("model minutes_left", 16'(minutes_left), 16'(m.left));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic minutes(input int n);
        for (int i = 0; i < n; i++) begin
            one_minute = 1'b1; tick(); one_minute = 1'b0; tick();
        end
    endtask

    task automatic press_snooze();
        snooze_button = 1'b1; tick(); snooze_button = 1'b0;
    endtask

    task automatic press_stop();
        stop_button = 1'b1; tick(); stop_button = 1'b0;
    endtask

    task automatic retrigger(input logic [15:0] t);
        current_time = t - 16'h1; tick();
        current_time = t; tick();
    endtask

    initial begin
        tick(); tick();
        chk("reset sound", 16'(sound_alarm), 16'd0);
        chk("reset count", 16'(snooze_count), 16'd0);
        chk("reset left", 16'(minutes_left), 16'd0);
        reset = 1'b1;
        tick();

        // Ring and auto-off
        current_time = 16'h1040; tick();
        chk("trigger sound", 16'(sound_alarm), 16'd1);
        chk("trigger left", 16'(minutes_left), 16'd5);
        minutes(4);
        chk("ring last minute", 16'(minutes_left), 16'd1);
        minutes(1);
        chk("auto-off sound", 16'(sound_alarm), 16'd0);
        chk("auto-off left", 16'(minutes_left), 16'd0);
        tick(); tick(); tick();
        chk("no retrigger", 16'(sound_alarm), 16'd0);

        // Snooze cycle
        retrigger(16'h1040);
        chk("ring again", 16'(sound_alarm), 16'd1);
        press_snooze();
        chk("snooze snoozing", 16'(snoozing), 16'd1);
        chk("snooze sound", 16'(sound_alarm), 16'd0);
        chk("snooze count", 16'(snooze_count), 16'd1);
        chk("snooze left", 16'(minutes_left), 16'd9);
        minutes(9);
        chk("resume sound", 16'(sound_alarm), 16'd1);
        chk("resume left", 16'(minutes_left), 16'd5);

        // Snooze limit
        press_snooze(); minutes(9);
        press_snooze();
        chk("third snooze count", 16'(snooze_count), 16'd3);
        minutes(9);
        press_snooze();
        chk("limit sound", 16'(sound_alarm), 16'd1);
        chk("limit count", 16'(snooze_count), 16'd3);
        press_stop();
        chk("stop sound", 16'(sound_alarm), 16'd0);
        chk("stop count held", 16'(snooze_count), 16'd3);
        chk("stop left", 16'(minutes_left), 16'd0);

        // Priority: stop beats snooze and minute
        retrigger(16'h1040);
        press_snooze(); minutes(9);
        stop_button = 1'b1; snooze_button = 1'b1; one_minute = 1'b1; tick();
        stop_button = 1'b0; snooze_button = 1'b0; one_minute = 1'b0;
        chk("priority sound", 16'(sound_alarm), 16'd0);
        chk("priority snoozing", 16'(snoozing), 16'd0);
        chk("priority count", 16'(snooze_count), 16'd1);

        // Disable during snooze
        retrigger(16'h1040);
        press_snooze();
        alarm_enable = 1'b0; tick();
        chk("disable snoozing", 16'(snoozing), 16'd0);
        chk("disable left", 16'(minutes_left), 16'd0);
        alarm_enable = 1'b1; tick();

        // Asynchronous reset mid-ring
        retrigger(16'h1040);
        #3 reset = 1'b0;
        #1 chk("async reset sound", 16'(sound_alarm), 16'd0);
        current_time = 16'h0000; alarm_time = 16'h0000;
        tick(); tick();
        reset = 1'b1;
        tick(); tick(); tick();
        chk("no power-up ring", 16'(sound_alarm), 16'd0);

        // Set-to-now across midnight wrap
        current_time = 16'h2359; tick();
        current_time = 16'h0000; tick();
        chk("wrap ring", 16'(sound_alarm), 16'd1);
        press_stop();

        // Random phase
        alarm_time = 16'h0630;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0)
                current_time = ($urandom_range(0, 1) != 0) ? 16'h0630 : 16'h0629;
            one_minute    = ($urandom_range(0, 2) == 0);
            snooze_button = ($urandom_range(0, 9) == 0);
            stop_button   = ($urandom_range(0, 39) == 0);
            alarm_enable  = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 999) == 0) begin
                #2 reset = 1'b0;
                #2 reset = 1'b1;
            end
            tick();
        end
        one_minute = 1'b0; snooze_button = 1'b0; stop_button = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
